fpnew_classifier_pipe: RTL and testbench

FPNEW_CLASSIFIER_PIPE -- requirements
Module: fpnew_classifier_pipe

---
 rtl/fpnew_classifier_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_fpnew_classifier_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_classifier_pipe.sv
// Per-lane floating-point classifier (FCLASS one-hot plus info flags) feeding a ready/valid register pipeline.
// Optional output-side NaN/sNaN statistics counters are enabled by FPNEW_CLASSIFIER_PIPE_STATS_EN.
package fpnew_pkg_versacore;
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction
endpackage

module fpnew_classifier_pipe
    import fpnew_pkg_versacore::*;
#(
    parameter fp_format_e  FpFormat    = fp_format_e'(0),
    parameter int unsigned NumLanes    = 4,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned TagWidth    = 4,
    localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [NumLanes*WIDTH-1:0]    operands_i,
    input  logic [NumLanes-1:0]          is_boxed_i,
    input  logic [NumLanes-1:0]          lane_mask_i,
    input  logic [TagWidth-1:0]          tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output fp_info_t [NumLanes-1:0]      info_o,
    output logic [NumLanes*10-1:0]       class_o,
    output logic [NumLanes-1:0]          lane_mask_o,
    output logic [TagWidth-1:0]          tag_o,
`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
    input  logic                         stats_clr_i,
    output logic [15:0]                  nan_cnt_o,
    output logic [15:0]                  snan_cnt_o,
`endif
    output logic                         busy_o
);
    localparam int unsigned EXP = exp_bits(FpFormat);
    localparam int unsigned MAN = man_bits(FpFormat);
    localparam int unsigned DW  = NumLanes * 8 + NumLanes * 10 + NumLanes + TagWidth;
    localparam int          NPR = int'(NumPipeRegs);

    fp_info_t [NumLanes-1:0]    comb_info;
    logic [NumLanes*10-1:0]     comb_class;
    logic [DW-1:0]              comb_data;
    logic [DW-1:0]              out_data;

    for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
        logic [WIDTH-1:0] op;
        logic [EXP-1:0]   e;
        logic [MAN-1:0]   m;
        logic             s;
        fp_info_t         info;
        logic [9:0]       cls;

        assign op = operands_i[gi*WIDTH +: WIDTH];
        assign s  = op[WIDTH-1];
        assign e  = op[WIDTH-2 -: EXP];
        assign m  = op[MAN-1:0];

        // Unboxed operands are treated as the canonical quiet NaN.
        always_comb begin
            info = '0;
            cls  = '0;
            if (lane_mask_i[gi]) begin
                info.is_boxed = is_boxed_i[gi];
                if (!is_boxed_i[gi]) begin
                    info.is_nan   = 1'b1;
                    info.is_quiet = 1'b1;
                    cls[9]        = 1'b1;
                end else if (e == '1) begin
                    if (m == '0) begin
                        info.is_inf = 1'b1;
                        if (s) cls[0] = 1'b1; else cls[7] = 1'b1;
                    end else begin
                        info.is_nan        = 1'b1;
                        info.is_signalling = !m[MAN-1];
                        info.is_quiet      = m[MAN-1];
                        if (m[MAN-1]) cls[9] = 1'b1; else cls[8] = 1'b1;
                    end
                end else if (e == '0) begin
                    if (m == '0) begin
                        info.is_zero = 1'b1;
                        if (s) cls[3] = 1'b1; else cls[4] = 1'b1;
                    end else begin
                        info.is_subnormal = 1'b1;
                        if (s) cls[2] = 1'b1; else cls[5] = 1'b1;
                    end
                end else begin
                    info.is_normal = 1'b1;
                    if (s) cls[1] = 1'b1; else cls[6] = 1'b1;
                end
            end
        end

        assign comb_info[gi]            = info;
        assign comb_class[gi*10 +: 10]  = cls;
    end

    assign comb_data = {comb_info, comb_class, lane_mask_i, tag_i};

    if (NumPipeRegs == 0) begin : g_comb
        assign out_data    = comb_data;
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        logic [NumPipeRegs-1:0] valid_q;
        logic [DW-1:0]          data_q    [NumPipeRegs];
        logic [NumPipeRegs-1:0] src_valid;
        logic [DW-1:0]          src_data  [NumPipeRegs];
        logic [NumPipeRegs:0]   ready;

        // A stage may load when empty or when its current beat moves on this cycle.
        always_comb begin
            ready[NumPipeRegs] = out_ready_i;
            for (int i = NPR - 1; i >= 0; i--) begin
                ready[i] = !valid_q[i] || ready[i+1];
            end
        end

        always_comb begin
            src_valid[0] = in_valid_i;
            src_data[0]  = comb_data;
            for (int i = 1; i < NPR; i++) begin
                src_valid[i] = valid_q[i-1];
                src_data[i]  = data_q[i-1];
            end
        end

        // Data only captures real beats so outputs keep the last beat rather than bubble garbage.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= '0;
                for (int i = 0; i < NPR; i++) data_q[i] <= '0;
            end else begin
                for (int i = 0; i < NPR; i++) begin
                    if (ready[i]) begin
                        valid_q[i] <= src_valid[i];
                        if (src_valid[i]) data_q[i] <= src_data[i];
                    end
                end
            end
        end

        assign out_data    = data_q[NumPipeRegs-1];
        assign out_valid_o = valid_q[NumPipeRegs-1];
        assign in_ready_o  = ready[0];
        assign busy_o      = |valid_q;
    end

    assign {info_o, class_o, lane_mask_o, tag_o} = out_data;

`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
    logic [15:0] nan_cnt_q, snan_cnt_q;
    logic [4:0]  nan_n, snan_n;
    logic [16:0] nan_sum, snan_sum;

    always_comb begin
        nan_n  = '0;
        snan_n = '0;
        for (int l = 0; l < int'(NumLanes); l++) begin
            nan_n  = nan_n  + 5'(info_o[l].is_nan);
            snan_n = snan_n + 5'(info_o[l].is_signalling);
        end
    end

    assign nan_sum  = {1'b0, nan_cnt_q}  + {12'b0, nan_n};
    assign snan_sum = {1'b0, snan_cnt_q} + {12'b0, snan_n};

    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            nan_cnt_q  <= '0;
            snan_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i) begin
            nan_cnt_q  <= nan_sum[16]  ? 16'hFFFF : nan_sum[15:0];
            snan_cnt_q <= snan_sum[16] ? 16'hFFFF : snan_sum[15:0];
        end
    end

    assign nan_cnt_o  = nan_cnt_q;
    assign snan_cnt_o = snan_cnt_q;
`endif
endmodule

// File: tb/tb_fpnew_classifier_pipe.sv
// Directed plus randomized bench for fpnew_classifier_pipe (FP32, 4 lanes, 2 stages) with a queue-based reference.
module tb_fpnew_classifier_pipe;
    import fpnew_pkg_versacore::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [127:0]         operands_i;
    logic [3:0]           is_boxed_i;
    logic [3:0]           lane_mask_i;
    logic [3:0]           tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    fp_info_t [3:0]       info_o;
    logic [39:0]          class_o;
    logic [3:0]           lane_mask_o;
    logic [3:0]           tag_o;
    logic                 busy_o;
`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
    logic                 stats_clr_i;
    logic [15:0]          nan_cnt_o;
    logic [15:0]          snan_cnt_o;
`endif

    fpnew_classifier_pipe #(
        .FpFormat    (FP32),
        .NumLanes    (4),
        .NumPipeRegs (2),
        .TagWidth    (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operands_i  (operands_i),
        .is_boxed_i  (is_boxed_i),
        .lane_mask_i (lane_mask_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .info_o      (info_o),
        .class_o     (class_o),
        .lane_mask_o (lane_mask_o),
        .tag_o       (tag_o),
`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
        .stats_clr_i (stats_clr_i),
        .nan_cnt_o   (nan_cnt_o),
        .snan_cnt_o  (snan_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [39:0] cls;
        logic [31:0] info;
        logic [3:0]  mask;
        logic [3:0]  tag;
    } beat_t;

    beat_t          sb[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             n_out   = 0;
    bit             quiet   = 0;

    logic           s_valid, s_busy, s_in_ready, s_acc;
    logic [39:0]    s_cls;
    fp_info_t [3:0] s_info;
    logic [3:0]     s_mask, s_tag;
    logic [15:0]    s_nan, s_snan;
    bit             stall_prev = 0;
    logic [79:0]    held;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference classification from the FCLASS rules, one lane at a time.
    function automatic beat_t ref_beat(input logic [127:0] ops, input logic [3:0] bx,
                                       input logic [3:0] mk, input logic [3:0] tg);
        beat_t b;
        b.cls = '0; b.info = '0; b.mask = mk; b.tag = tg;
        for (int l = 0; l < 4; l++) begin
            logic [31:0] x;
            int          e, m, k;
            bit          s;
            fp_info_t    fi;
            x = ops[l*32 +: 32];
            e = int'(x[30:23]);
            m = int'(x[22:0]);
            s = x[31];
            fi = '0;
            k = -1;
            if (mk[l]) begin
                fi.is_boxed = bx[l];
                if (!bx[l]) begin
                    fi.is_nan = 1; fi.is_quiet = 1; k = 9;
                end else if (e == 255 && m != 0) begin
                    fi.is_nan = 1;
                    if (m < (1 << 22)) begin fi.is_signalling = 1; k = 8; end
                    else begin fi.is_quiet = 1; k = 9; end
                end else if (e == 255) begin
                    fi.is_inf = 1; k = s ? 0 : 7;
                end else if (e == 0 && m == 0) begin
                    fi.is_zero = 1; k = s ? 3 : 4;
                end else if (e == 0) begin
                    fi.is_subnormal = 1; k = s ? 2 : 5;
                end else begin
                    fi.is_normal = 1; k = s ? 1 : 6;
                end
            end
            b.info[l*8 +: 8] = fi;
            if (k >= 0) b.cls = b.cls | (40'd1 << (l*10 + k));
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 3))
            0: e = 8'd0;
            1: e = 8'd255;
            default: e = 8'($urandom_range(1, 254));
        endcase
        case ($urandom_range(0, 4))
            0: m = 23'd0;
            1: m = 23'd1;
            2: m = 23'h400000;
            3: m = 23'($urandom) & 23'h3FFFFF;
            default: m = 23'($urandom);
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Sampled at the falling edge: models accepts/resets and scores every output transfer.
    task automatic mon();
        s_valid = out_valid_o; s_busy = busy_o; s_in_ready = in_ready_o;
        s_cls = class_o; s_info = info_o; s_mask = lane_mask_o; s_tag = tag_o;
        s_acc = 1'b0;
`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
        s_nan = nan_cnt_o; s_snan = snan_cnt_o;
`else
        s_nan = '0; s_snan = '0;
`endif
        if (rst_i) begin
            sb.delete();
            stall_prev = 0;
            return;
        end
        if (stall_prev) begin
            chk("stall_valid", out_valid_o, 1'b1);
            chk("stall_data", {class_o, info_o, lane_mask_o, tag_o}, held);
        end
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", out_valid_o, 1'b0);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("class", class_o, b.cls);
                chk("info", info_o, b.info);
                chk("mask", lane_mask_o, b.mask);
                chk("tag", tag_o, b.tag);
            end
            n_out++;
            if (!quiet) $display("[TB] out tag=%0d mask=%b class=%h", tag_o, lane_mask_o, class_o);
        end
        if (in_valid_i && in_ready_o) begin
            sb.push_back(ref_beat(operands_i, is_boxed_i, lane_mask_i, tag_i));
            s_acc = 1'b1;
        end
        stall_prev = out_valid_o && !out_ready_i;
        held = {class_o, info_o, lane_mask_o, tag_o};
    endtask

    task automatic cyc();
        @(negedge clk_i);
        mon();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_one(input logic [127:0] ops, input logic [3:0] bx,
                            input logic [3:0] mk, input logic [3:0] tg, input string name);
        int n;
        operands_i = ops; is_boxed_i = bx; lane_mask_i = mk; tag_i = tg;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        cyc();
        chk({name, "_accept"}, s_acc, 1'b1);
        in_valid_i = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!s_valid && n < 10);
        chk({name, "_latency"}, n, 2);
    endtask

    task automatic drain(input int cycles);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    initial begin
        int k, c, base;
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        operands_i = '0; is_boxed_i = '0; lane_mask_i = '0; tag_i = '0;
`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
        stats_clr_i = 1'b0;
`endif
        @(posedge clk_i); #1;
        cyc(); cyc();
        rst_i = 1'b0;
        operands_i = {4{32'h3F800000}}; is_boxed_i = 4'hF; lane_mask_i = 4'hF; tag_i = 4'h5;
        cyc();
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_ready", s_in_ready, 1'b1);
        chk("rst_data", {s_cls, s_info, s_mask, s_tag}, 80'd0);

        send_one({32'h80000000, 32'h7FC00000, 32'hFF800001, 32'h7F800000}, 4'hF, 4'hF, 4'd1, "specials");
        chk("specials_class", s_cls, {10'h008, 10'h200, 10'h100, 10'h080});

        send_one({32'h0, 32'h0, 32'h00000001, 32'h00000001}, 4'b1110, 4'hF, 4'd2, "unboxed");
        chk("unboxed_class", s_cls[9:0], 10'h200);
        chk("unboxed_nan", s_info[0].is_nan, 1'b1);
        chk("unboxed_boxed", s_info[0].is_boxed, 1'b0);
        chk("unboxed_sig", s_info[0].is_signalling, 1'b0);
        chk("boxed_sub_class", s_cls[19:10], 10'h020);

        send_one({32'h7F800001, 32'hC0000000, 32'h80000001, 32'h00000000}, 4'hF, 4'b0101, 4'd3, "mask");
        chk("mask_lane1", {s_cls[19:10], s_info[1]}, 18'd0);
        chk("mask_lane3", {s_cls[39:30], s_info[3]}, 18'd0);
        chk("mask_out", s_mask, 4'b0101);

        send_one({4{32'h3F800000}}, 4'hF, 4'h0, 4'd4, "empty_mask");
        chk("empty_mask_class", s_cls, 40'd0);

        // Sustained throughput with downstream always ready.
        base = n_out; k = 0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            operands_i = {rand_op(), rand_op(), rand_op(), rand_op()};
            in_valid_i = 1'b1; tag_i = 4'(i);
            cyc();
            if (s_acc) k++;
        end
        chk("thru_accepts", k, 8);
        drain(3);
        chk("thru_outputs", n_out - base, 8);

        // Ten back-to-back beats with out_ready toggling 1,0,1,0...
        base = n_out; k = 0; c = 0;
        while ((n_out - base) < 10 && c < 100) begin
            out_ready_i = (c % 2 == 0);
            in_valid_i  = (k < 10);
            tag_i       = 4'(k);
            operands_i  = {rand_op(), rand_op(), rand_op(), rand_op()};
            is_boxed_i  = 4'($urandom); lane_mask_i = 4'($urandom);
            cyc();
            if (s_acc) k++;
            c++;
        end
        chk("b2b_outputs", n_out - base, 10);
        drain(4);
        chk("b2b_sb_empty", sb.size(), 0);

        // Reset with two beats held inside the pipe.
        out_ready_i = 1'b0; in_valid_i = 1'b1; tag_i = 4'd7;
        cyc(); cyc();
        chk("inflight_busy", busy_o, 1'b1);
        in_valid_i = 1'b0; rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        cyc();
        chk("midrst_valid", s_valid, 1'b0);
        chk("midrst_busy", s_busy, 1'b0);
        chk("midrst_ready", s_in_ready, 1'b1);
        base = n_out;
        drain(6);
        chk("midrst_no_stale", n_out - base, 0);

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            operands_i  = {rand_op(), rand_op(), rand_op(), rand_op()};
            is_boxed_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            lane_mask_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            tag_i       = 4'($urandom);
            cyc();
        end
        drain(5);
        chk("rand_sb_empty", sb.size(), 0);

`ifdef FPNEW_CLASSIFIER_PIPE_STATS_EN
        stats_clr_i = 1'b1; cyc(); stats_clr_i = 1'b0;
        operands_i = {32'h3F800000, 32'h00000001, 32'h3F800000, 32'h7F800001};
        is_boxed_i = 4'b1011; lane_mask_i = 4'hF; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin in_valid_i = 1'b1; cyc(); end
        drain(4);
        chk("stats_nan3", s_nan, 16'd6);
        chk("stats_snan3", s_snan, 16'd3);
        stats_clr_i = 1'b1; cyc(); stats_clr_i = 1'b0;
        is_boxed_i = 4'hF; quiet = 1;
        for (int i = 0; i < 70000; i++) begin in_valid_i = 1'b1; cyc(); end
        drain(4);
        quiet = 0;
        chk("stats_nan_sat", s_nan, 16'hFFFF);
        chk("stats_snan_sat", s_snan, 16'hFFFF);
        stats_clr_i = 1'b1; cyc(); stats_clr_i = 1'b0;
        cyc();
        chk("stats_clr", {s_nan, s_snan}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
